pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bus between the fetch unit, instruction memory and decode.
// Groups the instruction-memory lookup (imem_addr/imem_instr) with the IF/ID
// pipeline register outputs (ifid_instr/ifid_pc1/ifid_valid).
//
// Handshake: there is no ready path. ifid_valid qualifies ifid_instr and
// ifid_pc1 for exactly the cycle it is high. Decode must accept the
// instruction that cycle; back-pressure is applied through the stall input.
// imem_instr is expected combinationally for the current imem_addr.
interface pc_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc1;
  logic        ifid_valid;

  // Fetch unit side
  modport master (
    output imem_addr,
    input  imem_instr,
    output ifid_instr,
    output ifid_pc1,
    output ifid_valid
  );

  // Memory / decode side
  modport slave (
    input  imem_addr,
    output imem_instr,
    input  ifid_instr,
    input  ifid_pc1,
    input  ifid_valid
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and IF/ID pipeline register.
// States: BOOT (one bubble cycle after reset), RUN (fetching), HALT (sticky
// until reset). Redirect priority: halt_req > jump > branch_taken > PC+1.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count.
// state_dbg exposes the FSM state: 0 = BOOT, 1 = RUN, 2 = HALT.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  input  logic          halt_req,
  pc_fetch_unit_if.master fbus,
  output logic          halted,
  output logic [1:0]    state_dbg
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;
  logic        kill;
  logic        load_valid;
  logic        run_stall;

  assign pc_plus1       = pc + 32'd1;  // wraps modulo 2^32
  assign jump_tgt       = {pc_plus1[31:26], jump_index};
  assign fbus.imem_addr = pc;
  assign halted         = (state == ST_HALT);
  assign state_dbg      = state;

  // Any redirect or halt turns the instruction being fetched into a bubble.
  assign kill       = flush | jump | branch_taken | halt_req;
  assign load_valid = (state == ST_RUN) && !stall && !kill;
  assign run_stall  = (state == ST_RUN) && stall;

  // Next-PC selection with halt holding the PC.
  always_comb begin
    next_pc = pc_plus1;
    if (halt_req)          next_pc = pc;
    else if (jump)         next_pc = jump_tgt;
    else if (branch_taken) next_pc = branch_target;
  end

  // FSM, PC and IF/ID register; reset aborts everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_BOOT;
      pc              <= RESET_PC;
      fbus.ifid_instr <= 32'h0;
      fbus.ifid_pc1   <= 32'h0;
      fbus.ifid_valid <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          fbus.ifid_instr <= 32'h0;
          fbus.ifid_pc1   <= 32'h0;
          fbus.ifid_valid <= 1'b0;
          state           <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            // Stall holds everything; a concurrent flush only kills IF/ID.
            if (flush) begin
              fbus.ifid_instr <= 32'h0;
              fbus.ifid_pc1   <= 32'h0;
              fbus.ifid_valid <= 1'b0;
            end
          end else begin
            pc <= next_pc;
            if (kill) begin
              fbus.ifid_instr <= 32'h0;
              fbus.ifid_pc1   <= 32'h0;
              fbus.ifid_valid <= 1'b0;
            end else begin
              fbus.ifid_instr <= fbus.imem_instr;
              fbus.ifid_pc1   <= pc_plus1;
              fbus.ifid_valid <= 1'b1;
            end
            if (halt_req) state <= ST_HALT;
          end
        end
        default: begin
          // HALT (and any illegal encoding) emits bubbles forever.
          fbus.ifid_instr <= 32'h0;
          fbus.ifid_pc1   <= 32'h0;
          fbus.ifid_valid <= 1'b0;
          state           <= ST_HALT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters of valid fetches and stalled RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (load_valid && (fetch_count != 32'hFFFFFFFF))
        fetch_count <= fetch_count + 32'd1;
      if (run_stall && (stall_count != 32'hFFFFFFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`else
  // Counter qualifiers are only consumed when the counters are built.
  logic unused_cnt;
  assign unused_cnt = load_valid ^ run_stall;
`endif

endmodule
